// File: rtl/l2_victim_select.sv
// Victim-way selection for an 8-set, 4-way L2: tracks per-line validity, consults an
// external pseudo-LRU array and holds off misses until an in-flight LRU update lands.
module l2_victim_select #(
  parameter int LRU_LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_index,
  input  logic       req_hit,
  input  logic [1:0] req_way,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic [1:0] resp_way,
  output logic       resp_fill,
  input  logic       inv_valid,
  input  logic [2:0] inv_index,
  input  logic [1:0] inv_way,
  output logic       lru_load,
  output logic [2:0] lru_index,
  output logic [1:0] lru_mru,
  input  logic [1:0] lru_in
);

  localparam int CW = (LRU_LAT < 1) ? 1 : $clog2(LRU_LAT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STALL  = 2'd1,
    SELECT = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [2:0]      cap_index_r;
  logic            cap_hit_r;
  logic [1:0]      cap_way_r;
  logic [3:0]      valid_r [8];
  logic [CW-1:0]   pend_cnt_r;
  logic [2:0]      pend_index_r;
  logic [1:0]      resp_way_r;
  logic            resp_fill_r;
  logic [3:0]      set_valid_s;
  logic [2:0]      inv_pick_s;
  logic [1:0]      victim_s;
  logic            fill_s;
  logic            stall_s;

  // Returns {found, way} for the lowest-numbered invalid way of a set.
  function automatic logic [2:0] lowest_invalid(input logic [3:0] v);
    logic [2:0] r;
    r = 3'b000;
    if (!v[0]) begin
      r = 3'b100;
    end else if (!v[1]) begin
      r = 3'b101;
    end else if (!v[2]) begin
      r = 3'b110;
    end else if (!v[3]) begin
      r = 3'b111;
    end else begin
      r = 3'b000;
    end
    return r;
  endfunction

  // Victim choice: hit way, else first hole in the set, else the array's LRU way.
  always_comb begin
    set_valid_s = valid_r[cap_index_r];
    inv_pick_s  = lowest_invalid(set_valid_s);
    victim_s    = lru_in;
    fill_s      = 1'b0;
    if (cap_hit_r) begin
      victim_s = cap_way_r;
      fill_s   = 1'b0;
    end else if (inv_pick_s[2]) begin
      victim_s = inv_pick_s[1:0];
      fill_s   = 1'b1;
    end else begin
      victim_s = lru_in;
      fill_s   = 1'b0;
    end
  end

  // A miss to the set whose LRU update is still in flight must wait for lru_in to settle.
  assign stall_s = !req_hit && (pend_cnt_r != {CW{1'b0}}) && (req_index == pend_index_r);

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          if (stall_s) begin
            state_s = STALL;
          end else begin
            state_s = SELECT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      STALL: begin
        if (pend_cnt_r == {CW{1'b0}}) begin
          state_s = SELECT;
        end else begin
          state_s = STALL;
        end
      end
      SELECT: state_s = RESP;
      RESP: begin
        if (resp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register and request capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cap_index_r <= 3'd0;
      cap_hit_r   <= 1'b0;
      cap_way_r   <= 2'd0;
    end else begin
      state_r <= state_s;
      if (state_r == IDLE && req_valid) begin
        cap_index_r <= req_index;
        cap_hit_r   <= req_hit;
        cap_way_r   <= req_way;
      end
    end
  end

  // Line validity; the SELECT set is written last so it wins over a same-cycle invalidate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        valid_r[i] <= 4'b0000;
      end
    end else begin
      if (inv_valid) begin
        valid_r[inv_index][inv_way] <= 1'b0;
      end
      if (state_r == SELECT) begin
        valid_r[cap_index_r][victim_s] <= 1'b1;
      end
    end
  end

  // Pending-update countdown and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_cnt_r   <= {CW{1'b0}};
      pend_index_r <= 3'd0;
      resp_way_r   <= 2'd0;
      resp_fill_r  <= 1'b0;
    end else begin
      if (state_r == SELECT) begin
        pend_cnt_r   <= CW'(LRU_LAT);
        pend_index_r <= cap_index_r;
        resp_way_r   <= victim_s;
        resp_fill_r  <= fill_s;
      end else if (pend_cnt_r != {CW{1'b0}}) begin
        pend_cnt_r <= pend_cnt_r - CW'(1);
      end
    end
  end

  assign req_ready  = (state_r == IDLE);
  assign resp_valid = (state_r == RESP);
  assign resp_way   = resp_way_r;
  assign resp_fill  = resp_fill_r;
  assign lru_load   = (state_r == SELECT);
  assign lru_mru    = (state_r == SELECT) ? victim_s : 2'b00;
  assign lru_index  = (state_r == IDLE) ? req_index : cap_index_r;

endmodule

// File: tb/tb_l2_victim_select.sv
// Bench for l2_victim_select: transaction-level model plus an LRU-array environment,
// directed scenarios with literal expectations, then randomized traffic.
module tb_l2_victim_select;
  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_index;
  logic       req_hit;
  logic [1:0] req_way;
  logic       resp_valid;
  logic       resp_ready;
  logic [1:0] resp_way;
  logic       resp_fill;
  logic       inv_valid;
  logic [2:0] inv_index;
  logic [1:0] inv_way;
  logic       lru_load;
  logic [2:0] lru_index;
  logic [1:0] lru_mru;
  logic [1:0] lru_in;

  always #5 clk = ~clk;

  l2_victim_select #(.LRU_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index),
    .req_hit(req_hit), .req_way(req_way),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_way(resp_way),
    .resp_fill(resp_fill),
    .inv_valid(inv_valid), .inv_index(inv_index), .inv_way(inv_way),
    .lru_load(lru_load), .lru_index(lru_index), .lru_mru(lru_mru), .lru_in(lru_in)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Environment: true-LRU array by timestamp, updates visible LAT cycles after lru_load
  int unsigned stamp [8][4];
  int unsigned tick = 0;
  logic [1:0]  lru_way [8];
  typedef struct { int at; int idx; int way; } upd_t;
  upd_t upd_q[$];
  assign lru_in = lru_way[lru_index];

  // Transaction model
  bit mval [8][4];
  bit m_busy;
  int m_sel, m_idx, m_way, m_rway;
  bit m_hit, m_rfill;
  bit have_load;
  int last_load, pidx;
  int got_way[$];
  int got_fill[$];
  int last_lat;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic lru_touch(input int s, input int w);
    int best;
    tick++;
    stamp[s][w] = tick;
    best = 0;
    for (int k = 1; k < 4; k++) if (stamp[s][k] < stamp[s][best]) best = k;
    lru_way[s] = 2'(best);
  endtask

  task automatic model_reset();
    m_busy = 0; have_load = 0; m_rway = 0; m_rfill = 0; pidx = 0; last_load = 0;
    for (int s = 0; s < 8; s++) for (int w = 0; w < 4; w++) mval[s][w] = 0;
  endtask

  task automatic step(input bit rv, input int ri, input bit rh, input int rw, input bit rr,
                      input bit iv, input int ii, input int iw, input bit rst);
    int rem, vic;
    bit stall, sel, vfill, found;
    @(negedge clk);
    while (upd_q.size() > 0 && upd_q[0].at <= cyc) begin
      lru_touch(upd_q[0].idx, upd_q[0].way);
      void'(upd_q.pop_front());
    end
    rst_n = rst ? 1'b0 : 1'b1;
    req_valid = rv; req_index = 3'(ri); req_hit = rh; req_way = 2'(rw);
    resp_ready = rr; inv_valid = iv; inv_index = 3'(ii); inv_way = 2'(iw);
    if (rst) model_reset();
    #1;
    sel = m_busy && (cyc == m_sel);
    vic = 0; vfill = 0;
    if (sel) begin
      if (m_hit) vic = m_way;
      else begin
        found = 0;
        for (int w = 0; w < 4; w++) if (!found && !mval[m_idx][w]) begin found = 1; vic = w; vfill = 1; end
        if (!found) vic = int'(lru_way[m_idx]);
      end
    end
    chk("req_ready", int'(req_ready), m_busy ? 0 : 1);
    chk("resp_valid", int'(resp_valid), (m_busy && cyc > m_sel) ? 1 : 0);
    chk("lru_load", int'(lru_load), int'(sel));
    chk("lru_index", int'(lru_index), m_busy ? m_idx : ri);
    chk("lru_mru", int'(lru_mru), vic);
    if (rst) begin
      chk("rst_resp_way", int'(resp_way), 0);
      chk("rst_resp_fill", int'(resp_fill), 0);
    end else if (m_busy && cyc > m_sel) begin
      chk("resp_way", int'(resp_way), m_rway);
      chk("resp_fill", int'(resp_fill), int'(m_rfill));
    end
    if (lru_load) upd_q.push_back('{cyc + LAT, int'(lru_index), int'(lru_mru)});
    if (!rst && resp_valid && resp_ready) begin
      got_way.push_back(int'(resp_way));
      got_fill.push_back(int'(resp_fill));
    end
    if (!rst) begin
      if (iv) mval[ii][iw] = 0;
      if (sel) begin
        mval[m_idx][vic] = 1; m_rway = vic; m_rfill = vfill;
        have_load = 1; last_load = cyc; pidx = m_idx;
      end
      if (m_busy) begin
        if (cyc > m_sel && rr) m_busy = 0;
      end else if (rv) begin
        rem = have_load ? (LAT - (cyc - last_load) + 1) : 0;
        if (rem < 0) rem = 0;
        stall = !rh && rem > 0 && ri == pidx;
        m_busy = 1; m_idx = ri; m_hit = rh; m_way = rw;
        m_sel = cyc + 1 + (stall ? rem : 0);
      end
    end
    cyc++;
  endtask

  task automatic txn(input int idx, input bit hit, input int way, input int rr_hold,
                     input bit inv_on_sel, input int ii, input int iw, input bit rst_on_sel);
    int n, hold;
    bit is_sel, rr;
    hold = rr_hold; last_lat = -1; n = 0;
    step(1, idx, hit, way, 1, 0, 0, 0, 0);
    chk("accepted", int'(m_busy), 1);
    while (m_busy && n < 40) begin
      n++;
      is_sel = (cyc == m_sel);
      rr = 1;
      if (cyc > m_sel && hold > 0) begin rr = 0; hold--; end
      step(0, idx, 0, 0, rr, inv_on_sel && is_sel, ii, iw, rst_on_sel && is_sel);
      if (resp_valid && last_lat < 0) last_lat = n;
    end
    chk("txn_done", int'(m_busy), 0);
  endtask

  task automatic chk_log(input string name, input int pos, input int way, input int fill);
    if (got_way.size() > pos) begin
      chk({name, "_way"}, got_way[pos], way);
      chk({name, "_fill"}, got_fill[pos], fill);
    end else begin
      chk({name, "_present"}, got_way.size(), pos + 1);
    end
  endtask

  initial begin
    for (int s = 0; s < 8; s++) begin
      lru_way[s] = 2'd0;
      for (int w = 0; w < 4; w++) stamp[s][w] = 0;
    end
    model_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_index = 3'd0; req_hit = 1'b0; req_way = 2'd0;
    resp_ready = 1'b0; inv_valid = 1'b0; inv_index = 3'd0; inv_way = 2'd0;
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // five misses to set 3: fill ways 0..3, then the LRU way (0)
    got_way.delete(); got_fill.delete();
    repeat (5) txn(3, 0, 0, 0, 0, 0, 0, 0);
    chk_log("m3_0", 0, 0, 1); chk_log("m3_1", 1, 1, 1); chk_log("m3_2", 2, 2, 1);
    chk_log("m3_3", 3, 3, 1); chk_log("m3_4", 4, 0, 0);

    // hit set 5 way 2
    got_way.delete(); got_fill.delete();
    txn(5, 1, 2, 0, 0, 0, 0, 0);
    chk_log("hit5", 0, 2, 0);
    chk("hit5_lat", last_lat, 2);

    // hits to set 1 ways 3,2,1,0 then a back-to-back miss stalls and picks LRU way 3
    got_way.delete(); got_fill.delete();
    for (int w = 3; w >= 0; w--) txn(1, 1, w, 0, 0, 0, 0, 0);
    txn(1, 0, 0, 0, 0, 0, 0, 0);
    chk_log("stall1", 4, 3, 0);
    chk("stall1_lat", last_lat, 3);

    // miss to set 6 right after an update to set 2: no stall
    got_way.delete(); got_fill.delete();
    txn(2, 1, 1, 0, 0, 0, 0, 0);
    txn(6, 0, 0, 0, 0, 0, 0, 0);
    chk("nostall6_lat", last_lat, 2);
    chk_log("miss6", 1, 0, 1);

    // set 4: fill, invalidate way 1, refill it; then invalidate/set collision on way 2
    got_way.delete(); got_fill.delete();
    repeat (4) txn(4, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 4, 1, 0);
    txn(4, 0, 0, 0, 0, 0, 0, 0);
    chk_log("refill4", 4, 1, 1);
    step(0, 0, 0, 0, 1, 1, 4, 2, 0);
    txn(4, 0, 0, 0, 1, 4, 2, 0);
    chk_log("coll4", 5, 2, 1);
    txn(4, 0, 0, 0, 0, 0, 0, 0);
    chk_log("full4", 6, 0, 0);

    // back-pressure for 3 cycles, then reset during SELECT
    got_way.delete(); got_fill.delete();
    txn(7, 1, 3, 3, 0, 0, 0, 0);
    chk_log("bp7", 0, 3, 0);
    txn(4, 0, 0, 0, 0, 0, 0, 1);
    chk("rst_noresp", got_way.size(), 1);
    txn(4, 0, 0, 0, 0, 0, 0, 0);
    chk_log("post_rst4", 1, 0, 1);

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      step(bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
           int'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), ($urandom_range(0, 149) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/l2_victim_select.md
L2_VICTIM_SELECT -- requirements
Module: l2_victim_select

Interface
REQ-001 SHALL have parameter LRU_LAT, default 2, meaning cycles from lru_load assertion until lru_in reflects the update.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req_valid, input, 1, access request present.
REQ-005 SHALL have port req_ready, output, 1, request accepted when high with req_valid.
REQ-006 SHALL have port req_index, input, 3, set index.
REQ-007 SHALL have port req_hit, input, 1, tag hit (1) or miss (0).
REQ-008 SHALL have port req_way, input, 2, hitting way; ignored on a miss.
REQ-009 SHALL have port resp_valid, output, 1, result available.
REQ-010 SHALL have port resp_ready, input, 1, consumer accepts result.
REQ-011 SHALL have port resp_way, output, 2, hit way or chosen victim.
REQ-012 SHALL have port resp_fill, output, 1, victim was an invalid way.
REQ-013 SHALL have ports inv_valid (input, 1), inv_index (input, 3) and inv_way (input, 2), invalidating one line.
REQ-014 SHALL have ports lru_load (output, 1), lru_index (output, 3) and lru_mru (output, 2), the update port of the 8-set, 4-way pseudo-LRU array.
REQ-015 SHALL have port lru_in, input, 2, the array's combinational LRU way for lru_index.

Function
REQ-016 SHALL implement states IDLE, STALL, SELECT and RESP.
REQ-017 SHALL drive req_ready=1 only in IDLE; all other states drive 0.
REQ-018 SHALL, in IDLE on req_valid, capture index, hit and way and then go to STALL if the request is a miss, the pending counter is nonzero and the captured index equals pend_index; otherwise go to SELECT.
REQ-019 SHALL keep a pending counter that loads LRU_LAT on every lru_load, decrements by 1 per cycle to 0 (saturating), and records pend_index = lru_index.
REQ-020 SHALL stay in STALL while the pending counter is nonzero and enter SELECT in the cycle after it reaches 0.
REQ-021 SHALL drive lru_index = req_index in IDLE and the captured index in all other states.
REQ-022 SHALL choose the victim in SELECT as follows: hit gives the captured way; a miss with any invalid way gives the lowest-numbered invalid way (resp_fill=1); otherwise it gives lru_in (resp_fill=0).
REQ-023 SHALL, in SELECT, assert lru_load=1 for exactly one cycle with lru_mru=victim, set valid[index][victim]=1 and register resp_way/resp_fill, then go to RESP.
REQ-024 SHALL hold lru_load=0 and lru_mru=0 outside SELECT.
REQ-025 SHALL hold resp_valid=1 with stable resp_way/resp_fill in RESP and return to IDLE on resp_ready; resp_ready outside RESP is ignored.
REQ-026 SHALL produce a response with latency from acceptance to resp_valid of 2 cycles without a stall, or 2 plus the remaining pending-count cycles with a stall.
REQ-027 SHALL clear valid[inv_index][inv_way] on inv_valid in any state, without an LRU update.
REQ-028 SHALL, when an invalidate and a SELECT set hit the same set/way in one cycle, let the set win (bit ends 1).
REQ-029 SHALL sample an invalidate arriving in the same cycle as SELECT before victim choice only from the next cycle (SELECT uses the registered valid bits).
REQ-030 SHALL handle hits to an invalid way as given: victim = req_way, the valid bit is set, resp_fill=0.

Reset
REQ-031 SHALL, while rst_n=0, immediately force state IDLE, all 32 valid bits 0, pending counter 0, pend_index 0, resp_way 0, resp_fill 0, resp_valid 0, lru_load 0, lru_mru 0 and req_ready 1.
REQ-032 SHALL abandon any in-flight request on reset mid-operation, issue no lru_load, and accept no new request until rst_n=1.

Verification
REQ-033 SHALL cover: after reset, five misses to index 3 -> resp_way 0,1,2,3 with resp_fill=1, then the fifth gives resp_way=lru_in with resp_fill=0.
REQ-034 SHALL cover: hit index 5 way 2 -> lru_load=1, lru_index=5, lru_mru=2 one cycle after acceptance; resp_valid the next cycle with resp_way=2.
REQ-035 SHALL cover: a miss on index 1 accepted the cycle after a resp/IDLE following an update to index 1 -> STALL until counter=0, SELECT reads the updated lru_in, and no lru_load occurs during STALL.
REQ-036 SHALL cover: a miss to index 6 right after an update to index 2 -> no stall, 2-cycle latency.
REQ-037 SHALL cover: fill set 4, invalidate way 1, miss set 4 -> resp_way=1, resp_fill=1; invalidate plus set in the same cycle on the same way -> bit remains 1.
REQ-038 SHALL cover: resp_ready held 0 for 3 cycles -> resp_way stable and req_ready=0; rst_n pulsed in SELECT -> no lru_load, valid bits cleared.
